// File: rtl/sha_compress_pkg.sv
// Shared SHA-256 definitions for sha_compress: word sizes, FSM encoding,
// per-round K table, IV and the sigma helpers.
package sha_compress_pkg;

  localparam int WORD_S = 32;
  localparam int WARR_S = 512;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_t;

  // a is the most significant word, so a 256-bit H vector casts straight in.
  typedef struct packed {
    logic [WORD_S-1:0] a, b, c, d, e, f, g, h;
  } hstate_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [WORD_S-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [WORD_S-1:0] ror(input logic [WORD_S-1:0] x, input int n);
    return (x >> n) | (x << (WORD_S - n));
  endfunction

  function automatic logic [WORD_S-1:0] bsig0(input logic [WORD_S-1:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [WORD_S-1:0] bsig1(input logic [WORD_S-1:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [WORD_S-1:0] ssig0(input logic [WORD_S-1:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_S-1:0] ssig1(input logic [WORD_S-1:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha_compress_round.sv
// One combinational SHA-256 round: working variables a..h plus K and the
// current schedule word produce the next a..h.
module sha_compress_round
  import sha_compress_pkg::*;
(
  input  hstate_t           s,
  input  logic [WORD_S-1:0] k,
  input  logic [WORD_S-1:0] w,
  output hstate_t           s_next
);

  logic [WORD_S-1:0] ch, maj, t1, t2;

  always_comb begin
    ch  = (s.e & s.f) ^ (~s.e & s.g);
    maj = (s.a & s.b) ^ (s.a & s.c) ^ (s.b & s.c);
    t1  = s.h + bsig1(s.e) + ch + k + w;
    t2  = bsig0(s.a) + maj;
    s_next = '{a: t1 + t2, b: s.a, c: s.b, d: s.c,
               e: s.d + t1, f: s.e, g: s.f, h: s.g};
  end

endmodule

// File: rtl/sha_compress.sv
// Iterative SHA-256 compression, one round per clock with a rolling 16-word
// schedule window. SHA_FEEDFWD_EN adds the saved input state to the result.
module sha_compress
  import sha_compress_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [WARR_S-1:0] W,
  input  logic [255:0]      H_in,
  output logic [255:0]      H_out,
  output logic              en_next,
  output logic              busy
);

  state_t                       state_q, state_d;
  hstate_t                      st, st_next;
  logic [15:0][WORD_S-1:0]      w_win;
  logic [WORD_S-1:0]            w_new;
  logic [5:0]                   cnt;
  logic                         last_round;
`ifdef SHA_FEEDFWD_EN
  hstate_t                      hs;
`endif

  assign last_round = (cnt == 6'(ROUNDS - 1));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_ROUND;
      ST_ROUND: if (last_round) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  sha_compress_round u_round (
    .s      (st),
    .k      (K[cnt]),
    .w      (w_win[0]),
    .s_next (st_next)
  );

  assign w_new = ssig1(w_win[14]) + w_win[9] + ssig0(w_win[1]) + w_win[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= '0;
      w_win   <= '0;
      cnt     <= '0;
      H_out   <= '0;
      en_next <= 1'b0;
`ifdef SHA_FEEDFWD_EN
      hs      <= '0;
`endif
    end else begin
      en_next <= 1'b0;
      case (state_q)
        ST_IDLE: if (en) begin
          // Word 0 sits in the top bits of W; w_win[0] is always the next word consumed.
          for (int i = 0; i < 16; i++) w_win[i] <= W[WARR_S-1-WORD_S*i -: WORD_S];
          st  <= hstate_t'(H_in);
          cnt <= '0;
`ifdef SHA_FEEDFWD_EN
          hs  <= hstate_t'(H_in);
`endif
        end
        ST_ROUND: begin
          st <= st_next;
          for (int i = 0; i < 15; i++) w_win[i] <= w_win[i+1];
          w_win[15] <= w_new;
          cnt <= cnt + 6'd1;
        end
        ST_DONE: begin
`ifdef SHA_FEEDFWD_EN
          H_out <= {st.a + hs.a, st.b + hs.b, st.c + hs.c, st.d + hs.d,
                    st.e + hs.e, st.f + hs.f, st.g + hs.g, st.h + hs.h};
`else
          H_out <= st;
`endif
          en_next <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
